// File: rtl/spi_slave_enc_regs.sv
// SPI responder decoding the ENC424J600-style opcode set against a local 32x8 register file.
// All pins are oversampled on clk; commands, writes and transaction ends are single-cycle strobes.
module spi_slave_enc_regs #(
    parameter bit SLAVE_SAMPLING = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] status_byte,
    input  logic [4:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       host_we,
    output logic [7:0] host_rdata,
    output logic [7:0] cmd_byte,
    output logic       cmd_valid,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       txn_done
);
    typedef enum logic [2:0] {IDLE, OPCODE, RDATA, WDATA, IGNORE} state_t;
    state_t state, state_next;

    logic       sck_s1, sck_s2, sck_s3;
    logic       cs_s1, cs_s2, mosi_s1, mosi_s2;
    logic       rise_q, fall_q, mosi_q, cs_q, cs_q2;
    logic [1:0] settle;
    logic       armed, seen_low;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift, rx_byte;
    logic [4:0] addr;
    logic       status_rd;
    logic [7:0] regfile [32];
    logic       sample_q, shift_q, cs_fall, cs_rise, last_bit, op_done, spi_we;

    assign sample_q   = SLAVE_SAMPLING ? fall_q : rise_q;
    assign shift_q    = SLAVE_SAMPLING ? rise_q : fall_q;
    assign cs_fall    = armed & ~cs_q & cs_q2;
    assign cs_rise    = cs_q & ~cs_q2;
    assign last_bit   = sample_q & (bit_cnt == 3'd7) & ~cs_q;
    assign rx_byte    = {rx_shift[6:0], mosi_q};
    assign op_done    = (state == OPCODE) & last_bit;
    assign spi_we     = (state == WDATA) & last_bit;
    assign host_rdata = regfile[host_addr];

    // Pin synchronizers plus a registered edge-detect stage; armed blocks the fake CS_N
    // fall that the reset value of the CS_N pipeline would otherwise produce after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            cs_q2   <= 1'b1;
            settle  <= 2'd0;
            armed   <= 1'b0;
            MISO_OE <= 1'b0;
        end else begin
            sck_s1  <= SCK;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= CS_N;
            cs_s2   <= cs_s1;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            rise_q  <= sck_s2 & ~sck_s3;
            fall_q  <= ~sck_s2 & sck_s3;
            mosi_q  <= mosi_s2;
            cs_q    <= cs_s2;
            cs_q2   <= cs_q;
            MISO_OE <= ~cs_s2;
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end else if (cs_q) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cs_fall) state_next = OPCODE;
            end
            OPCODE: begin
                if (last_bit) begin
                    if (rx_byte == 8'hC8 || rx_byte[7:5] == 3'b000) state_next = RDATA;
                    else if (rx_byte[7:5] == 3'b010)                state_next = WDATA;
                    else                                            state_next = IGNORE;
                end
            end
            RDATA: begin
                if (last_bit && status_rd) state_next = IGNORE;
            end
            default: ;
        endcase
        if (cs_q) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            tx_shift  <= 8'h00;
            addr      <= 5'd0;
            status_rd <= 1'b0;
            seen_low  <= 1'b0;
            MISO      <= 1'b0;
            cmd_byte  <= 8'h00;
            cmd_valid <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 8'h00;
            wr_en     <= 1'b0;
            txn_done  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            wr_en     <= 1'b0;
            txn_done  <= cs_rise & seen_low;
            if (cs_fall) seen_low <= 1'b1;
            else if (cs_rise) seen_low <= 1'b0;

            if (state == IDLE || cs_q) bit_cnt <= 3'd0;
            else if (sample_q) bit_cnt <= bit_cnt + 3'd1;
            if (sample_q) rx_shift <= rx_byte;

            if (op_done) begin
                addr      <= rx_byte[4:0];
                status_rd <= (rx_byte == 8'hC8);
                if (rx_byte == 8'hC8) tx_shift <= status_byte;
                else tx_shift <= regfile[rx_byte[4:0]];
                if (rx_byte[7:6] == 2'b11 && rx_byte != 8'hC8) begin
                    cmd_byte  <= rx_byte;
                    cmd_valid <= 1'b1;
                end
            end

            // Reload for the next read byte happens on the sampling edge, so the following
            // shift edge already presents the new MSB.
            if (state == RDATA && !cs_q) begin
                if (last_bit && !status_rd) begin
                    addr     <= addr + 5'd1;
                    tx_shift <= regfile[addr + 5'd1];
                end else if (shift_q) begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end

            if (spi_we) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= rx_byte;
                addr    <= addr + 5'd1;
            end

            if (state != RDATA) MISO <= 1'b0;
            else if (shift_q && !cs_q) MISO <= tx_shift[7];
        end
    end

    // The SPI write is issued last so it wins a same-address collision with the host.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regfile[i] <= 8'h00;
        end else begin
            if (host_we) regfile[host_addr] <= host_wdata;
            if (spi_we) regfile[addr] <= rx_byte;
        end
    end
endmodule
